// File: rtl/uba_pkg.sv
// Shared types for the interrupt arbiter: PI level width, busINTR width, FSM states.
// No logic, no latency.
// No flow control; constants and types only.
package uba_pkg;

    localparam int PI_W      = 3;
    localparam int BUSINTR_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uba_intr_chan.sv
// One interrupt channel: rising-edge detector plus sticky pend bit.
// Latency: pend sets on the first edge that samples devINTR high after low.
// No backpressure; ack clears pend unless a new edge arrives the same cycle.
module uba_intr_chan (
    input  logic clk,
    input  logic rst,
    input  logic dev,
    input  logic en,
    input  logic ack,
    output logic pend
);

    logic prev;
    logic rise;

    assign rise = dev & ~prev;

    // prev resets to 0, so a level held through reset release counts as an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= dev;
            if (rise && en) begin
                pend <= 1'b1;
            end else if (ack) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uba_intr_arb.sv
// Interrupt arbiter: latches device requests, drives PI levels, answers CPU who-are-you cycles.
// Latency: busINTR 1 cycle after pend; response 2 cycles after sampled wruREAD.
// No backpressure; a held wruREAD yields one response, next one needs wruREAD low first.
module uba_intr_arb
    import uba_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       devINTR,
    input  logic [NCH-1:0]       chEN,
    input  logic [PI_W*NCH-1:0]  chPI,
    input  logic                 wruREAD,
    input  logic [PI_W-1:0]      busPI,
    output logic [BUSINTR_W:1]   busINTR,
    output logic [NCH-1:0]       devACK,
    output logic                 wruVALID,
    output logic [CW-1:0]        wruCH,
    output logic                 wruNONE,
    output logic [NCH-1:0]       statINT
);

    arb_state_t          state;
    logic [PI_W-1:0]     cap_pi;
    logic [NCH-1:0]      pend;
    logic [NCH-1:0]      match;
    logic [NCH-1:0]      match_nxt;
    logic [BUSINTR_W:1]  lvl;
    logic [CW-1:0]       sel;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        uba_intr_chan u_chan (
            .clk  (clk),
            .rst  (rst),
            .dev  (devINTR[i]),
            .en   (chEN[i]),
            .ack  (devACK[i]),
            .pend (pend[i])
        );
    end

    assign statINT = pend;

    always_comb begin
        lvl = '0;
        for (int k = 1; k <= BUSINTR_W; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (pend[i] && chEN[i] && (chPI[PI_W*i +: PI_W] == PI_W'(k))) begin
                    lvl[k] = 1'b1;
                end
            end
        end
    end

    // a captured level of 0 never matches, even against channels left at PI 0
    always_comb begin
        match_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            match_nxt[i] = pend[i] & chEN[i] & (chPI[PI_W*i +: PI_W] == cap_pi) & (cap_pi != '0);
        end
    end

    // ascending scan so the highest matching index wins
    always_comb begin
        sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (match[i]) begin
                sel = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busINTR <= '0;
        end else begin
            busINTR <= lvl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cap_pi   <= '0;
            match    <= '0;
            wruVALID <= 1'b0;
            wruNONE  <= 1'b0;
            devACK   <= '0;
            wruCH    <= '0;
        end else begin
            wruVALID <= 1'b0;
            wruNONE  <= 1'b0;
            devACK   <= '0;
            case (state)
                IDLE: begin
                    if (wruREAD) begin
                        cap_pi <= busPI;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    match <= match_nxt;
                    state <= RESP;
                end
                RESP: begin
                    if (|match) begin
                        wruVALID <= 1'b1;
                        devACK   <= {{(NCH-1){1'b0}}, 1'b1} << sel;
                        wruCH    <= sel;
                    end else begin
                        wruNONE <= 1'b1;
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (!wruREAD) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uba_intr_arb.sv
// Bench for uba_intr_arb (NCH=4): directed stimulus, response scoreboard, state checks.
module tb_uba_intr_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  devINTR;
    logic [3:0]  chEN;
    logic [11:0] chPI;
    logic        wruREAD;
    logic [2:0]  busPI;
    logic [7:1]  busINTR;
    logic [3:0]  devACK;
    logic        wruVALID;
    logic [1:0]  wruCH;
    logic        wruNONE;
    logic [3:0]  statINT;

    typedef struct {
        bit         none;
        int         ch;
        logic [3:0] ack;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    uba_intr_arb #(.NCH(4), .CW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .devINTR  (devINTR),
        .chEN     (chEN),
        .chPI     (chPI),
        .wruREAD  (wruREAD),
        .busPI    (busPI),
        .busINTR  (busINTR),
        .devACK   (devACK),
        .wruVALID (wruVALID),
        .wruCH    (wruCH),
        .wruNONE  (wruNONE),
        .statINT  (statINT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a clock edge; the response is due 3 edges later.
    task automatic start_read(input logic [2:0] pi, input bit none, input int ch,
                              input logic [3:0] ack, input bit push);
        exp_t e;
        if (push) begin
            e.none = none;
            e.ch   = ch;
            e.ack  = ack;
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
        busPI   = pi;
        wruREAD = 1'b1;
    endtask

    task automatic stop_read();
        wruREAD = 1'b0;
        busPI   = 3'd0;
        tick(3);
    endtask

    // Monitor: every response pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (wruVALID || wruNONE) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_resp: valid=%0b none=%0b ch=%0d ack=%b at cyc %0d, expected no response",
                             wruVALID, wruNONE, wruCH, devACK, cyc);
                end else begin
                    e = sb.pop_front();
                    if ((wruVALID === e.none) || (wruNONE !== e.none) || (cyc != e.cyc) ||
                        (devACK !== e.ack) || (!e.none && (int'(wruCH) != e.ch))) begin
                        n_bad++;
                        $display("FAIL resp: got valid=%0b none=%0b ch=%0d ack=%b cyc=%0d, expected none=%0b ch=%0d ack=%b cyc=%0d",
                                 wruVALID, wruNONE, wruCH, devACK, cyc, e.none, e.ch, e.ack, e.cyc);
                    end
                end
            end else if (devACK != 4'b0) begin
                n_vec++;
                n_bad++;
                $display("FAIL stray_ack: devACK=%b without wruVALID, expected 0000", devACK);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        devINTR = 4'b0;
        chEN    = 4'hF;
        chPI    = {3'd7, 3'd5, 3'd5, 3'd1};
        wruREAD = 1'b0;
        busPI   = 3'd0;
        tick(2);
        check("rst_stat",  32'(statINT),  32'h0);
        check("rst_bus",   32'(busINTR),  32'h0);
        check("rst_pulse", {29'd0, wruVALID, wruNONE, 1'b0} | 32'(devACK), 32'h0);
        check("rst_ch",    32'(wruCH),    32'h0);
        rst = 1'b1;
        tick(2);

        // single request at level 5
        devINTR[1] = 1'b1;
        tick(1);
        check("pend_1",     32'(statINT), 32'b0010);
        check("bus_lag",    32'(busINTR), 32'h0);
        tick(1);
        check("bus_lvl5",   32'(busINTR), 32'b0010000);

        // two at level 5, held read grants highest index once
        devINTR[2] = 1'b1;
        tick(2);
        check("pend_12",    32'(statINT), 32'b0110);
        start_read(3'd5, 1'b0, 2, 4'b0100, 1'b1);
        tick(10);
        stop_read();
        check("after_g2",   32'(statINT), 32'b0010);
        check("ch_hold2",   32'(wruCH),   32'd2);
        start_read(3'd5, 1'b0, 1, 4'b0010, 1'b1);
        tick(4);
        stop_read();
        check("after_g1",   32'(statINT), 32'b0000);
        check("ch_hold1",   32'(wruCH),   32'd1);
        check("bus_clear",  32'(busINTR), 32'h0);

        // levels 1 and 7; read at unused level 3 and at level 0
        devINTR = 4'hF;
        tick(2);
        check("pend_03",    32'(statINT), 32'b1001);
        check("bus_l17",    32'(busINTR), 32'b1000001);
        start_read(3'd3, 1'b1, 0, 4'b0000, 1'b1);
        tick(4);
        stop_read();
        check("none3_pend", 32'(statINT), 32'b1001);
        check("none3_ch",   32'(wruCH),   32'd1);
        start_read(3'd0, 1'b1, 0, 4'b0000, 1'b1);
        tick(4);
        stop_read();
        check("none0_pend", 32'(statINT), 32'b1001);

        // masked channel keeps pend but drops out of busINTR and matching
        chEN = 4'b1110;
        tick(1);
        check("mask_bus",   32'(busINTR), 32'b1000000);
        start_read(3'd1, 1'b1, 0, 4'b0000, 1'b1);
        tick(4);
        stop_read();
        check("mask_pend",  32'(statINT), 32'b1001);
        chEN = 4'hF;

        // new rising edge on ch3 coincides with its devACK
        devINTR[3] = 1'b0;
        tick(2);
        start_read(3'd7, 1'b0, 3, 4'b1000, 1'b1);
        tick(3);
        devINTR[3] = 1'b1;
        tick(1);
        check("ack_rise",   32'(statINT), 32'b1001);
        tick(1);
        stop_read();
        check("ack_rise2",  32'(statINT), 32'b1001);
        start_read(3'd7, 1'b0, 3, 4'b1000, 1'b1);
        tick(4);
        stop_read();
        check("g3_clear",   32'(statINT), 32'b0001);
        check("ch_hold3",   32'(wruCH),   32'd3);

        // reset while in SCAN, wruREAD kept high through release
        start_read(3'd1, 1'b0, 0, 4'b0000, 1'b0);
        tick(1);
        rst = 1'b0;
        #1;
        check("mid_rst_stat",  32'(statINT), 32'h0);
        check("mid_rst_bus",   32'(busINTR), 32'h0);
        check("mid_rst_pulse", {29'd0, wruVALID, wruNONE, 1'b0} | 32'(devACK), 32'h0);
        check("mid_rst_ch",    32'(wruCH),   32'h0);
        tick(2);
        rst = 1'b1;
        start_read(3'd1, 1'b0, 0, 4'b0001, 1'b1);
        tick(1);
        check("rel_pend",   32'(statINT), 32'b1111);
        tick(1);
        check("rel_bus",    32'(busINTR), 32'b1010001);
        tick(4);
        stop_read();
        check("rel_clear",  32'(statINT), 32'b1110);

        tick(5);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL missing_resp: %0d responses outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
